// File: rtl/q_seq_pkg.sv
// q_seq_pkg
// Shared definitions for the Q2 count-stream checker.
//   state_t      : checker FSM states (HUNT, VERIFY, LOCKED), 2-bit encoding
//   Q_WIDTH      : default stream width
//   Q_ERR_CNT_W  : default error counter width
//   next_exp()   : next expected stream value, (q + step) truncated to width.
//                  Operates on 32-bit containers, so stream widths up to 32.
package q_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int Q_WIDTH     = 8;
  localparam int Q_ERR_CNT_W = 16;

  // Modular add; the mask reproduces the natural wrap of a width-bit counter.
  function automatic logic [31:0] next_exp(input logic [31:0] q,
                                           input logic [31:0] step,
                                           input int unsigned width);
    logic [31:0] mask;
    if (width >= 32) mask = 32'hFFFF_FFFF;
    else             mask = (32'd1 << width) - 32'd1;
    return (q + step) & mask;
  endfunction

endpackage

// File: rtl/q_seq_checker_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, count <= 0
//   inc   : add one, holding once the count is all-ones
//   clr   : synchronous clear, takes priority over inc
//   count : current count (registered)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                  count_d = '0;
    else if (inc && !(&count_q)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/q_seq_checker.sv
// q_seq_checker
// Receive-side checker for the free-running Q2 count stream. Locks onto the
// arithmetic sequence q, q+STEP, q+2*STEP, ... and, while locked, flags and
// counts every sample that breaks it.
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   q_in       : stream sample under check
//   q_valid    : q_in is sampled only on edges where this is high
//   clr_count  : synchronous clear of err_count (and capture registers)
//   locked     : checker is locked to the sequence
//   err_pulse  : one-cycle strobe on an in-lock mismatch
//   err_count  : saturating count of in-lock mismatches
//   expected   : next value the checker expects
// Optional build macro Q_SEQ_CHECKER_CAPTURE_EN adds:
//   first_got / first_exp / first_vld : sample and expectation of the first
//   in-lock mismatch since reset or clr_count.
// All outputs are registered.
module q_seq_checker
  import q_seq_pkg::*;
#(
  parameter int          WIDTH      = Q_WIDTH,
  parameter int unsigned STEP       = 1,
  parameter int          LOCK_COUNT = 4,
  parameter int          ERR_CNT_W  = Q_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 q_valid,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
  output logic [WIDTH-1:0]     first_got,
  output logic [WIDTH-1:0]     first_exp,
  output logic                 first_vld,
`endif
  output logic [WIDTH-1:0]     expected
);

  // match_cnt only has to reach LOCK_COUNT, so size it for that value.
  localparam int              MC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_COUNT);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_inc;

  logic [WIDTH-1:0] seed_val;
  logic [WIDTH-1:0] adv_val;
  logic [MC_W-1:0]  match_cnt_inc;
  logic             is_match;

  assign seed_val      = WIDTH'(next_exp(32'(q_in), 32'(STEP), WIDTH));
  assign adv_val       = WIDTH'(next_exp(32'(expected_q), 32'(STEP), WIDTH));
  assign match_cnt_inc = match_cnt_q + MC_W'(1);
  assign is_match      = (q_in == expected_q);

  // Next-state and compare logic. Nothing moves unless q_valid is high;
  // a mismatch outside LOCKED just reseeds, only LOCKED mismatches count.
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (q_valid) begin
      case (state_q)
        HUNT: begin
          expected_d  = seed_val;
          match_cnt_d = '0;
          state_d     = VERIFY;
        end
        VERIFY: begin
          if (is_match) begin
            expected_d  = adv_val;
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == LOCK_TGT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            expected_d  = seed_val;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            expected_d = adv_val;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            locked_d    = 1'b0;
            expected_d  = seed_val;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        default: begin
          state_d     = HUNT;
          expected_d  = '0;
          match_cnt_d = '0;
          locked_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // clr_count beats a same-edge increment inside the counter.
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clr_count),
    .count (err_count)
  );

`ifdef Q_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_got_q, first_got_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic             first_vld_q, first_vld_d;

  // Latch only the first error; first_vld blocks later overwrites.
  always_comb begin
    first_got_d = first_got_q;
    first_exp_d = first_exp_q;
    first_vld_d = first_vld_q;
    if (clr_count) begin
      first_got_d = '0;
      first_exp_d = '0;
      first_vld_d = 1'b0;
    end else if (err_inc && !first_vld_q) begin
      first_got_d = q_in;
      first_exp_d = expected_q;
      first_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_got_q <= '0;
      first_exp_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      first_got_q <= first_got_d;
      first_exp_q <= first_exp_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign first_got = first_got_q;
  assign first_exp = first_exp_q;
  assign first_vld = first_vld_q;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_q_seq_checker.sv
// tb_q_seq_checker
// Drives two checker instances from one shared stream: dut_a with default
// parameters and dut_b with LOCK_COUNT=1, ERR_CNT_W=2 for saturation. Each is
// compared every cycle against a behavioural model of the sequence rules.
module tb_q_seq_checker;

  localparam int STEP_V = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       q_valid;
  logic       clr_count;
  logic [7:0] q_in;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_count_a;
  logic [7:0]  expected_a;
  logic        locked_b, err_pulse_b;
  logic [1:0]  err_count_b;
  logic [7:0]  expected_b;
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
  logic [7:0]  first_got_a, first_exp_a, first_got_b, first_exp_b;
  logic        first_vld_a, first_vld_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q_seq_checker #(.WIDTH(8), .STEP(STEP_V), .LOCK_COUNT(4), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid), .clr_count(clr_count),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a),
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
    .first_got(first_got_a), .first_exp(first_exp_a), .first_vld(first_vld_a),
`endif
    .expected(expected_a)
  );

  q_seq_checker #(.WIDTH(8), .STEP(STEP_V), .LOCK_COUNT(1), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .q_in(q_in), .q_valid(q_valid), .clr_count(clr_count),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b),
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
    .first_got(first_got_b), .first_exp(first_exp_b), .first_vld(first_vld_b),
`endif
    .expected(expected_b)
  );

  // Reference view: 'run' counts consecutive matches since the last seed,
  // lock holds once run reaches the lock threshold.
  typedef struct {
    bit seeded;
    int exp_v;
    int run;
    bit lck;
    int err;
    bit pulse;
    bit fv;
    int fg;
    int fe;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_next(input model_t m, input bit v, input int q,
                                        input bit clr, input int lock_n, input int err_max);
    model_t n = m;
    n.pulse = 1'b0;
    if (v) begin
      if (!m.seeded) begin
        n.seeded = 1'b1;
        n.exp_v  = (q + STEP_V) % 256;
        n.run    = 0;
      end else if (q == m.exp_v) begin
        n.exp_v = (m.exp_v + STEP_V) % 256;
        if (!m.lck) begin
          n.run = m.run + 1;
          if (n.run >= lock_n) n.lck = 1'b1;
        end
      end else begin
        if (m.lck) begin
          n.pulse = 1'b1;
          n.err   = (m.err + 1 > err_max) ? err_max : m.err + 1;
          if (!m.fv) begin
            n.fv = 1'b1;
            n.fg = q;
            n.fe = m.exp_v;
          end
        end
        n.lck   = 1'b0;
        n.exp_v = (q + STEP_V) % 256;
        n.run   = 0;
      end
    end
    if (clr) begin
      n.err = 0;
      n.fv  = 1'b0;
      n.fg  = 0;
      n.fe  = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic checkOutput();
    check("a_locked",    32'(locked_a),    32'(ma.lck));
    check("a_err_pulse", 32'(err_pulse_a), 32'(ma.pulse));
    check("a_err_count", 32'(err_count_a), 32'(ma.err));
    check("a_expected",  32'(expected_a),  32'(ma.exp_v));
    check("b_locked",    32'(locked_b),    32'(mb.lck));
    check("b_err_pulse", 32'(err_pulse_b), 32'(mb.pulse));
    check("b_err_count", 32'(err_count_b), 32'(mb.err));
    check("b_expected",  32'(expected_b),  32'(mb.exp_v));
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
    check("a_first_vld", 32'(first_vld_a), 32'(ma.fv));
    check("a_first_got", 32'(first_got_a), 32'(ma.fg));
    check("a_first_exp", 32'(first_exp_a), 32'(ma.fe));
    check("b_first_vld", 32'(first_vld_b), 32'(mb.fv));
    check("b_first_got", 32'(first_got_b), 32'(mb.fg));
    check("b_first_exp", 32'(first_exp_b), 32'(mb.fe));
`endif
  endtask

  // Called at a falling edge: drive, let one rising edge happen, advance the
  // model, then compare at the next falling edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] q, input bit c);
    rst       = r;
    q_valid   = v;
    q_in      = q;
    clr_count = c;
    @(posedge clk);
    if (r) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = model_next(ma, v, int'(q), c, 4, 65535);
      mb = model_next(mb, v, int'(q), c, 1, 3);
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic feed(input logic [7:0] q);
    applyStimulus(1'b0, 1'b1, q, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Seed plus four matches: dut_a locks with expected = start+5.
  task automatic lockFrom(input logic [7:0] start);
    for (int i = 0; i < 5; i++) feed(start + 8'(i));
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] rq;
    bit         rv, rc, rr;

    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1; q_valid = 1'b0; clr_count = 1'b0; q_in = 8'h00;
    @(negedge clk);

    // Reset state, with a valid sample on the reset edge that must be dropped.
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    check("rst_locked",   32'(locked_a),    32'd0);
    check("rst_expected", 32'(expected_a),  32'd0);
    check("rst_count",    32'(err_count_a), 32'd0);

    // Lock on 0x10..0x14.
    lockFrom(8'h10);
    check("t1_locked",   32'(locked_a),    32'd1);
    check("t1_expected", 32'(expected_a),  32'h15);
    check("t1_count",    32'(err_count_a), 32'd0);

    // Wrap 0xFD..0x01 while locked.
    doReset();
    lockFrom(8'hF8);
    for (int i = 0; i < 5; i++) begin
      feed(8'hFD + 8'(i));
      check("t2_locked", 32'(locked_a),    32'd1);
      check("t2_pulse",  32'(err_pulse_a), 32'd0);
    end
    check("t2_expected", 32'(expected_a), 32'h02);

    // Error and relock.
    doReset();
    lockFrom(8'h1B);
    check("t3_pre_exp", 32'(expected_a), 32'h20);
    feed(8'h25);
    check("t3_pulse",    32'(err_pulse_a), 32'd1);
    check("t3_count",    32'(err_count_a), 32'd1);
    check("t3_unlocked", 32'(locked_a),    32'd0);
    check("t3_expected", 32'(expected_a),  32'h26);
    feed(8'h26);
    check("t3_pulse_off", 32'(err_pulse_a), 32'd0);
    for (int i = 1; i < 4; i++) feed(8'h26 + 8'(i));
    check("t3_relocked", 32'(locked_a),    32'd1);
    check("t3_count2",   32'(err_count_a), 32'd1);

    // clr_count on the same edge as an in-lock mismatch.
    lockFrom(8'h50);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
    check("t5_clr_count", 32'(err_count_a), 32'd0);
    check("t5_clr_pulse", 32'(err_pulse_a), 32'd1);

    // Valid gaps while locked.
    doReset();
    lockFrom(8'h3B);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'hAA, 1'b0);
      check("t4_gap_locked", 32'(locked_a),   32'd1);
      check("t4_gap_exp",    32'(expected_a), 32'h40);
    end
    feed(8'h40);
    check("t4_pulse",    32'(err_pulse_a), 32'd0);
    check("t4_locked",   32'(locked_a),    32'd1);
    check("t4_expected", 32'(expected_a),  32'h41);

    // Reset while locked with three errors.
    doReset();
    for (int i = 0; i < 3; i++) begin
      lockFrom(8'h30);
      feed(8'h00);
    end
    lockFrom(8'h30);
    check("t5_pre_count", 32'(err_count_a), 32'd3);
    doReset();
    check("t5_rst_locked", 32'(locked_a),    32'd0);
    check("t5_rst_count",  32'(err_count_a), 32'd0);
    check("t5_rst_exp",    32'(expected_a),  32'd0);
    check("t5_rst_pulse",  32'(err_pulse_a), 32'd0);

    // Saturation on dut_b: five match/mismatch pairs.
    feed(8'h00);
    cur = 8'h00;
    for (int i = 0; i < 5; i++) begin
      cur = cur + 8'd1;
      feed(cur);
      check("t6_locked", 32'(locked_b), 32'd1);
      cur = cur + 8'h40;
      feed(cur);
      check("t6_pulse", 32'(err_pulse_b), 32'd1);
      check("t6_count", 32'(err_count_b), (i < 3) ? 32'(i + 1) : 32'd3);
    end
`ifdef Q_SEQ_CHECKER_CAPTURE_EN
    check("t6_first_vld", 32'(first_vld_b), 32'd1);
    check("t6_first_got", 32'(first_got_b), 32'h41);
    check("t6_first_exp", 32'(first_exp_b), 32'h02);
`endif

    // Random stream: mostly in-sequence with valid gaps, corruptions, clears
    // and occasional resets.
    for (int i = 0; i < 800; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom_range(0, 255));
      else                           rq = 8'(ma.exp_v);
      applyStimulus(rr, rv, rq, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
